// File: rtl/serial_rho_seq.sv
// serial_rho_seq: column-serial rho for SWAN256.
// Loads four columns a0..a3 of a half-state, folding them into the parity
// P = a0^a1^a2^a3 on the way in, then streams out y_i = P ^ a_i. Each y_i is
// the XOR of the three other columns. Load and emit never overlap.

// One column buffer slot: captures the stream word when its index is loaded.
module serial_rho_slot #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we_i,
  input  logic [0:W-1] d_i,
  output logic [0:W-1] q_o
);
  logic [0:W-1] q_q;

  // Hold the column until the next frame overwrites this slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q_q <= '0;
    else if (we_i) q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

module serial_rho_seq #(
  parameter int BLOCK_SIZE  = 256,
  parameter int SIDE_SIZE   = BLOCK_SIZE / 2,
  parameter int COLUMN_SIZE = SIDE_SIZE / 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [0:COLUMN_SIZE-1] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [0:COLUMN_SIZE-1] out_data,
  output logic                   out_last,
  output logic                   busy
);
  localparam int NCOL = 4;

  typedef enum logic {LOAD = 1'b0, EMIT = 1'b1} state_e;

  state_e                                 state_q;
  logic [1:0]                             cnt_q;
  logic [0:COLUMN_SIZE-1]                 par_q;
  logic [NCOL-1:0][0:COLUMN_SIZE-1]       buf_q;
  logic [NCOL-1:0]                        buf_we;
  logic                                   accept;
  logic                                   xfer;
  logic                                   last_col;

  // Handshake qualifiers. Reset and clr both gate the stream flags so no
  // transfer can be counted while the frame is being dropped.
  assign in_ready  = rst_n && (state_q == LOAD) && !clr;
  assign out_valid = rst_n && (state_q == EMIT) && !clr;
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign last_col  = (cnt_q == 2'd3);

  // Output column comes from registers only; forced to zero when not valid
  // so downstream never sees stale buffer contents.
  assign out_data = out_valid ? (buf_q[cnt_q] ^ par_q) : '0;
  assign out_last = out_valid && last_col;
  assign busy     = rst_n && ((state_q == EMIT) || (cnt_q != 2'd0));

  // Column buffer: one slot per column, written in arrival order.
  for (genvar c = 0; c < NCOL; c++) begin : g_slot
    assign buf_we[c] = accept && (cnt_q == 2'(c));
    serial_rho_slot #(.W(COLUMN_SIZE)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .we_i  (buf_we[c]),
      .d_i   (in_data),
      .q_o   (buf_q[c])
    );
  end

  // Sequencer: column counter, running parity and LOAD/EMIT phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= 2'd0;
      par_q   <= '0;
    end else if (clr) begin
      state_q <= LOAD;
      cnt_q   <= 2'd0;
      par_q   <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (accept) begin
            par_q <= par_q ^ in_data;
            if (last_col) begin
              state_q <= EMIT;
              cnt_q   <= 2'd0;
            end else begin
              cnt_q <= cnt_q + 2'd1;
            end
          end
        end
        EMIT: begin
          if (xfer) begin
            if (last_col) begin
              state_q <= LOAD;
              cnt_q   <= 2'd0;
              par_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 2'd1;
            end
          end
        end
        default: begin
          state_q <= LOAD;
          cnt_q   <= 2'd0;
          par_q   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_rho_seq.sv
// Directed + random bench for serial_rho_seq with a queue scoreboard.
module tb_serial_rho_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;

  int ncmp = 0;
  int nfail = 0;

  logic [32:0] exp_q[$];   // {last, data}
  logic [31:0] part[$];    // columns of the frame being loaded

  serial_rho_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model and output checker, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n || clr) begin
      part.delete();
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        part.push_back(in_data);
        if (part.size() == 4) begin
          for (int i = 0; i < 4; i++) begin
            logic [31:0] y;
            y = 32'h0;
            for (int j = 0; j < 4; j++) if (j != i) y = y ^ part[j];
            exp_q.push_back({(i == 3), y});
          end
          part.delete();
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", {out_last, out_data}, 33'h1_dead_beef);
        else chk("out_col", {out_last, out_data}, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [31:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 33'd0, 33'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", 33'(exp_q.size()), 33'd0);
    @(posedge clk); #1;
  endtask

  task automatic basic_frame();
    send(32'h1); send(32'h2); send(32'h4); send(32'h8);
  endtask

  initial begin
    int idx;
    int cyc;
    logic [31:0] cur;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b1; in_data = 32'h1234_5678; out_ready = 1'b1;
    #12;
    chk("rst_in_ready",  {32'd0, in_ready},  33'd0);
    chk("rst_out_valid", {32'd0, out_valid}, 33'd0);
    chk("rst_out_last",  {32'd0, out_last},  33'd0);
    chk("rst_busy",      {32'd0, busy},      33'd0);
    chk("rst_out_data",  {1'b0, out_data},   33'd0);
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic frame with latency checks.
    send(32'h1); send(32'h2); send(32'h4);
    chk("pre4_out_valid", {32'd0, out_valid}, 33'd0);
    chk("pre4_busy",      {32'd0, busy},      33'd1);
    send(32'h8);
    chk("lat_out_valid", {32'd0, out_valid}, 33'd1);
    chk("lat_first",     {out_last, out_data}, {1'b0, 32'h0000000E});
    chk("emit_in_ready", {32'd0, in_ready},  33'd0);
    drain();

    // All-ones, then alternating (parity must restart at zero).
    repeat (4) send(32'hFFFF_FFFF);
    drain();
    send(32'hAAAA_AAAA); send(32'h5555_5555); send(32'hAAAA_AAAA); send(32'h5555_5555);
    drain();

    // Back-pressure on column 1.
    out_ready = 1'b0;
    basic_frame();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_data",     {out_last, out_data}, {1'b0, 32'h0000000D});
      chk("bp_valid",    {32'd0, out_valid},   33'd1);
      chk("bp_in_ready", {32'd0, in_ready},    33'd0);
    end
    @(posedge clk); #1;
    drain();

    // clr mid-load.
    send(32'h11); send(32'h22);
    in_valid = 1'b1; in_data = 32'h33; clr = 1'b1;
    @(negedge clk);
    chk("clr_in_ready", {32'd0, in_ready}, 33'd0);
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_busy", {32'd0, busy}, 33'd0);
    basic_frame();
    drain();

    // Async reset mid-emit, after columns 0 and 1 have left.
    out_ready = 1'b0;
    send(32'hDEAD_0001); send(32'hBEEF_0002); send(32'hCAFE_0004); send(32'hF00D_0008);
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {32'd0, out_valid}, 33'd0);
    chk("arst_out_data",  {1'b0, out_data},   33'd0);
    chk("arst_busy",      {32'd0, busy},      33'd0);
    chk("arst_in_ready",  {32'd0, in_ready},  33'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    basic_frame();
    drain();

    // Random regression with valid/ready gaps.
    idx = 0; cyc = 0; cur = $urandom;
    while (idx < 4000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = cur;
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) begin
        idx++;
        cur = $urandom;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("rand_all_sent", 33'(idx), 33'd4000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
